// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller arbitrating between a load/store
// unit (LSB) and an instruction fetch port in front of a byte-wide RAM with
// one cycle of read latency.
//
// Ports
//   clk, rst, rdy        clock, synchronous active-high reset, clock enable
//   lsb_flag/is_write/addr/len/val_out  LSB request (len: 0=byte,1=half,3=word)
//   lsb_val_in, lsb_ok   LSB load data (zero-extended) and completion pulse
//   if_flag, if_addr     fetch request
//   if_ins, if_ok        fetched instruction and completion pulse
//   mem_din/dout/a/wr    RAM byte interface
//   io_buffer_full       UART buffer full
//
// Optional feature: define IO_STALL_EN to hold off stores to the I/O window
// (addr[17:16]==2'b11) while io_buffer_full is set. Without it the input is
// ignored.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        lsb_flag,
    input  logic        lsb_is_write,
    input  logic [31:0] lsb_addr,
    input  logic [1:0]  lsb_len,
    input  logic [31:0] lsb_val_out,
    output logic [31:0] lsb_val_in,
    output logic        lsb_ok,
    input  logic        if_flag,
    input  logic [31:0] if_addr,
    output logic [31:0] if_ins,
    output logic        if_ok,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state, state_next;
    logic [31:0] base, wdata, result, result_next;
    logic [2:0]  i, n, i_m1;
    logic        is_fetch, stall, take_lsb, take_if;

`ifdef IO_STALL_EN
    assign stall = lsb_flag && lsb_is_write && (lsb_addr[17:16] == 2'b11) && io_buffer_full;
`else
    logic unused_io;
    assign stall     = 1'b0;
    assign unused_io = io_buffer_full;
`endif

    // A stalled store still holds lsb_flag, so it also keeps fetch out.
    assign take_lsb = lsb_flag && !stall;
    assign take_if  = if_flag && !lsb_flag;

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else if (rdy)
            state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (take_lsb)     state_next = lsb_is_write ? WRITE : READ;
                   else if (take_if) state_next = READ;
            READ:  if (i == n)         state_next = DONE;
            WRITE: if (i == n - 3'd1)  state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Read data for the address issued at count i-1 arrives while count is i,
    // so the byte landing this cycle belongs to index i-1.
    assign i_m1 = i - 3'd1;
    always_comb begin
        result_next = result;
        if (i != 3'd0)
            result_next[{i_m1[1:0], 3'b000} +: 8] = mem_din;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            base       <= '0;
            wdata      <= '0;
            result     <= '0;
            n          <= '0;
            i          <= '0;
            is_fetch   <= 1'b0;
            lsb_val_in <= '0;
            if_ins     <= '0;
        end else if (rdy) begin
            case (state)
                IDLE: begin
                    i      <= '0;
                    result <= '0;
                    if (take_lsb) begin
                        base     <= lsb_addr;
                        n        <= {1'b0, lsb_len} + 3'd1;
                        wdata    <= lsb_val_out;
                        is_fetch <= 1'b0;
                    end else if (take_if) begin
                        base     <= if_addr;
                        n        <= 3'd4;
                        is_fetch <= 1'b1;
                    end
                end
                READ: begin
                    i      <= i + 3'd1;
                    result <= result_next;
                    if (i == n) begin
                        if (is_fetch) if_ins     <= result_next;
                        else          lsb_val_in <= result_next;
                    end
                end
                WRITE: i <= i + 3'd1;
                default: i <= '0;
            endcase
        end
    end

    // Outputs
    always_comb begin
        mem_a    = '0;
        mem_dout = '0;
        mem_wr   = 1'b0;
        lsb_ok   = 1'b0;
        if_ok    = 1'b0;
        case (state)
            READ:  mem_a = base + {29'd0, i};
            WRITE: begin
                mem_a    = base + {29'd0, i};
                mem_dout = wdata[{i[1:0], 3'b000} +: 8];
                mem_wr   = rdy;
            end
            DONE: begin
                lsb_ok = !is_fetch;
                if_ok  = is_fetch;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed testbench for mem_ctrl with a one-cycle-latency byte RAM model.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        lsb_flag, lsb_is_write;
    logic [31:0] lsb_addr, lsb_val_out, lsb_val_in;
    logic [1:0]  lsb_len;
    logic        lsb_ok;
    logic        if_flag, if_ok;
    logic [31:0] if_addr, if_ins;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full;

    int checks = 0;
    int errors = 0;
    int n_lsb_ok = 0;
    int n_if_ok = 0;

    logic [7:0]  ram [0:4095];
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .lsb_flag(lsb_flag), .lsb_is_write(lsb_is_write), .lsb_addr(lsb_addr),
        .lsb_len(lsb_len), .lsb_val_out(lsb_val_out), .lsb_val_in(lsb_val_in),
        .lsb_ok(lsb_ok), .if_flag(if_flag), .if_addr(if_addr), .if_ins(if_ins),
        .if_ok(if_ok), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
        .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    always @(posedge clk) begin
        if (pl_en)       ram[pl_addr] <= pl_data;
        else if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
        mem_din <= ram[mem_a[11:0]];
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (lsb_ok) n_lsb_ok++;
            if (if_ok)  n_if_ok++;
        end
    end

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        step();
        pl_en = 1'b0;
    endtask

    task automatic set_lsb(input logic wr, input logic [1:0] len, input logic [31:0] a, input logic [31:0] d);
        lsb_flag = 1'b1; lsb_is_write = wr; lsb_len = len; lsb_addr = a; lsb_val_out = d;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(); step();
        checks++; if (lsb_ok !== 1'b0)     begin errors++; $display("FAIL reset_lsb_ok got %b want 0", lsb_ok); end
        checks++; if (if_ok !== 1'b0)      begin errors++; $display("FAIL reset_if_ok got %b want 0", if_ok); end
        checks++; if (mem_wr !== 1'b0)     begin errors++; $display("FAIL reset_mem_wr got %b want 0", mem_wr); end
        checks++; if (mem_a !== 32'h0)     begin errors++; $display("FAIL reset_mem_a got %h want 0", mem_a); end
        checks++; if (mem_dout !== 8'h0)   begin errors++; $display("FAIL reset_mem_dout got %h want 0", mem_dout); end
        checks++; if (lsb_val_in !== 32'h0) begin errors++; $display("FAIL reset_lsb_val_in got %h want 0", lsb_val_in); end
        checks++; if (if_ins !== 32'h0)    begin errors++; $display("FAIL reset_if_ins got %h want 0", if_ins); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_fetch;
        if_flag = 1'b1; if_addr = 32'h100;
        step();  // acceptance edge E0
        for (int k = 0; k < 5; k++) begin
            checks++; if (if_ok !== 1'b0) begin errors++; $display("FAIL fetch_early_ok k=%0d got %b want 0", k, if_ok); end
            if (k < 4) begin
                checks++; if (mem_a !== 32'h100 + k) begin errors++; $display("FAIL fetch_addr k=%0d got %h want %h", k, mem_a, 32'h100 + k); end
                checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL fetch_wr k=%0d got %b want 0", k, mem_wr); end
            end
            step();
        end
        checks++; if (if_ok !== 1'b1)          begin errors++; $display("FAIL fetch_ok got %b want 1", if_ok); end
        checks++; if (if_ins !== 32'h00A00513) begin errors++; $display("FAIL fetch_ins got %h want 00a00513", if_ins); end
        checks++; if (mem_a !== 32'h0)         begin errors++; $display("FAIL fetch_done_addr got %h want 0", mem_a); end
        if_flag = 1'b0;
        step();
        checks++; if (if_ok !== 1'b0)          begin errors++; $display("FAIL fetch_ok_pulse got %b want 0", if_ok); end
        checks++; if (if_ins !== 32'h00A00513) begin errors++; $display("FAIL fetch_ins_hold got %h want 00a00513", if_ins); end
    endtask

    task automatic test_load_byte;
        set_lsb(1'b0, 2'd0, 32'h204, 32'h0);
        step();  // E0
        checks++; if (mem_a !== 32'h204) begin errors++; $display("FAIL load_addr got %h want 204", mem_a); end
        step();  // E1
        checks++; if (lsb_ok !== 1'b0)   begin errors++; $display("FAIL load_early_ok got %b want 0", lsb_ok); end
        step();  // E2
        checks++; if (lsb_ok !== 1'b1)   begin errors++; $display("FAIL load_ok got %b want 1", lsb_ok); end
        checks++; if (lsb_val_in !== 32'h000000F0) begin errors++; $display("FAIL load_val got %h want 000000f0", lsb_val_in); end
        lsb_flag = 1'b0;
        step();
    endtask

    task automatic test_store_half;
        set_lsb(1'b1, 2'd1, 32'h300, 32'h1234ABCD);
        step();  // E0
        checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h300, 8'hCD}) begin errors++; $display("FAIL store_b0 got wr=%b a=%h d=%h want 1 300 cd", mem_wr, mem_a, mem_dout); end
        step();  // E1
        checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h301, 8'hAB}) begin errors++; $display("FAIL store_b1 got wr=%b a=%h d=%h want 1 301 ab", mem_wr, mem_a, mem_dout); end
        step();  // E2
        checks++; if (lsb_ok !== 1'b1)   begin errors++; $display("FAIL store_ok got %b want 1", lsb_ok); end
        checks++; if (mem_wr !== 1'b0)   begin errors++; $display("FAIL store_done_wr got %b want 0", mem_wr); end
        lsb_flag = 1'b0;
        step(); step();
        checks++; if (ram[12'h300] !== 8'hCD) begin errors++; $display("FAIL store_ram0 got %h want cd", ram[12'h300]); end
        checks++; if (ram[12'h301] !== 8'hAB) begin errors++; $display("FAIL store_ram1 got %h want ab", ram[12'h301]); end
        checks++; if (ram[12'h302] !== 8'h77) begin errors++; $display("FAIL store_no_third got %h want 77", ram[12'h302]); end
    endtask

    task automatic test_priority;
        int l0, f0, k;
        l0 = n_lsb_ok; f0 = n_if_ok;
        set_lsb(1'b0, 2'd0, 32'h204, 32'h0);
        if_flag = 1'b1; if_addr = 32'h100;
        step();  // E0: LSB wins
        checks++; if (mem_a !== 32'h204) begin errors++; $display("FAIL prio_winner got %h want 204", mem_a); end
        step(); step();  // E2: DONE
        checks++; if (lsb_ok !== 1'b1)   begin errors++; $display("FAIL prio_lsb_ok got %b want 1", lsb_ok); end
        lsb_flag = 1'b0;
        step();  // IDLE
        checks++; if (mem_a !== 32'h0)   begin errors++; $display("FAIL prio_idle_addr got %h want 0", mem_a); end
        step();  // fetch accepted
        checks++; if (mem_a !== 32'h100) begin errors++; $display("FAIL prio_fetch_addr got %h want 100", mem_a); end
        k = 0;
        while (if_ok !== 1'b1 && k < 20) begin step(); k++; end
        checks++; if (k !== 5) begin errors++; $display("FAIL prio_fetch_latency got %0d want 5", k); end
        checks++; if (if_ins !== 32'h00A00513) begin errors++; $display("FAIL prio_ins got %h want 00a00513", if_ins); end
        if_flag = 1'b0;
        step(); step();
        checks++; if (n_lsb_ok - l0 !== 1) begin errors++; $display("FAIL prio_lsb_pulses got %0d want 1", n_lsb_ok - l0); end
        checks++; if (n_if_ok - f0 !== 1)  begin errors++; $display("FAIL prio_if_pulses got %0d want 1", n_if_ok - f0); end
    endtask

    task automatic test_rdy_stall;
        int k;
        set_lsb(1'b0, 2'd3, 32'h100, 32'h0);
        step();  // E0
        rdy = 1'b0;
        step(); step();
        checks++; if (mem_a !== 32'h100) begin errors++; $display("FAIL rdy_hold_addr got %h want 100", mem_a); end
        rdy = 1'b1;
        k = 0;
        while (lsb_ok !== 1'b1 && k < 20) begin step(); k++; end
        checks++; if (k !== 5) begin errors++; $display("FAIL rdy_load_latency got %0d want 5", k); end
        checks++; if (lsb_val_in !== 32'h00A00513) begin errors++; $display("FAIL rdy_load_val got %h want 00a00513", lsb_val_in); end
        lsb_flag = 1'b0;
        step();
        set_lsb(1'b1, 2'd0, 32'h500, 32'h0000005A);
        step();  // E0
        rdy = 1'b0; #1;
        checks++; if (mem_wr !== 1'b0)   begin errors++; $display("FAIL rdy_wr_forced got %b want 0", mem_wr); end
        step();
        checks++; if ({mem_wr, mem_a} !== {1'b0, 32'h500}) begin errors++; $display("FAIL rdy_wr_hold got wr=%b a=%h want 0 500", mem_wr, mem_a); end
        rdy = 1'b1; #1;
        checks++; if ({mem_wr, mem_dout} !== {1'b1, 8'h5A}) begin errors++; $display("FAIL rdy_wr_resume got wr=%b d=%h want 1 5a", mem_wr, mem_dout); end
        step();
        checks++; if (lsb_ok !== 1'b1)   begin errors++; $display("FAIL rdy_store_ok got %b want 1", lsb_ok); end
        lsb_flag = 1'b0;
        step();
        checks++; if (ram[12'h500] !== 8'h5A) begin errors++; $display("FAIL rdy_store_ram got %h want 5a", ram[12'h500]); end
    endtask

    task automatic test_reset_mid;
        int l0;
        l0 = n_lsb_ok;
        set_lsb(1'b1, 2'd3, 32'h400, 32'hDEADBEEF);
        step(); step(); step();  // now writing byte 2
        checks++; if ({mem_wr, mem_a} !== {1'b1, 32'h402}) begin errors++; $display("FAIL rstmid_b2 got wr=%b a=%h want 1 402", mem_wr, mem_a); end
        rst = 1'b1;
        step();
        checks++; if (mem_wr !== 1'b0)   begin errors++; $display("FAIL rstmid_wr got %b want 0", mem_wr); end
        checks++; if (mem_a !== 32'h0)   begin errors++; $display("FAIL rstmid_addr got %h want 0", mem_a); end
        rst = 1'b0; lsb_flag = 1'b0;
        step(); step(); step();
        checks++; if (n_lsb_ok - l0 !== 0)    begin errors++; $display("FAIL rstmid_no_ok got %0d want 0", n_lsb_ok - l0); end
        checks++; if (ram[12'h403] !== 8'h55) begin errors++; $display("FAIL rstmid_no_write got %h want 55", ram[12'h403]); end
    endtask

    task automatic test_io_stall;
        int wr_seen, k;
        wr_seen = 0;
        io_buffer_full = 1'b1;
        set_lsb(1'b1, 2'd0, 32'h00030000, 32'h000000A5);
`ifdef IO_STALL_EN
        if_flag = 1'b1; if_addr = 32'h100;
        for (int c = 0; c < 10; c++) begin
            step();
            if (mem_wr !== 1'b0 || mem_a !== 32'h0) wr_seen++;
        end
        checks++; if (wr_seen !== 0) begin errors++; $display("FAIL io_stall_blocked got %0d active cycles want 0", wr_seen); end
        io_buffer_full = 1'b0;
`endif
        step();
        checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h00030000, 8'hA5}) begin errors++; $display("FAIL io_write_start got wr=%b a=%h d=%h want 1 30000 a5", mem_wr, mem_a, mem_dout); end
        step();
        checks++; if (lsb_ok !== 1'b1) begin errors++; $display("FAIL io_store_ok got %b want 1", lsb_ok); end
        lsb_flag = 1'b0;
        io_buffer_full = 1'b0;
        k = 0;
        while (if_flag && if_ok !== 1'b1 && k < 20) begin step(); k++; end
        if (if_flag) begin
            checks++; if (if_ok !== 1'b1) begin errors++; $display("FAIL io_fetch_after got %b want 1", if_ok); end
            if_flag = 1'b0;
        end
        step();
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1;
        lsb_flag = 1'b0; lsb_is_write = 1'b0; lsb_addr = '0; lsb_len = '0; lsb_val_out = '0;
        if_flag = 1'b0; if_addr = '0; io_buffer_full = 1'b0;
        preload(12'h100, 8'h13);
        preload(12'h101, 8'h05);
        preload(12'h102, 8'hA0);
        preload(12'h103, 8'h00);
        preload(12'h204, 8'hF0);
        preload(12'h205, 8'h99);
        preload(12'h302, 8'h77);
        preload(12'h403, 8'h55);
        test_reset();
        test_fetch();
        test_load_byte();
        test_store_half();
        test_priority();
        test_rdy_stall();
        test_reset_mid();
        test_io_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
